// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline while iterating, then shows the result for one cycle.
module ex_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_n;

    logic             rem_sel;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic [CW-1:0]    cnt;

    logic             is_signed, sign1, sign2;
    logic [WIDTH-1:0] abs1, abs2;
    logic             div_zero, ovf, special;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_n, quo_n, q_fix, r_fix, calc_res;
    logic             last;

    always_comb begin
        is_signed   = ~op[0];
        sign1       = is_signed & src1[WIDTH-1];
        sign2       = is_signed & src2[WIDTH-1];
        abs1        = sign1 ? -src1 : src1;
        abs2        = sign2 ? -src2 : src2;
        div_zero    = (src2 == '0);
        ovf         = is_signed & (src1 == MIN) & (src2 == '1);
        special     = div_zero | ovf;
        // Divide by zero wins over overflow; both finish without iterating
        if (div_zero)
            special_res = op[1] ? src1 : '1;
        else
            special_res = op[1] ? '0 : MIN;
    end

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        rem_n    = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_n    = {quo[WIDTH-2:0], ~diff[WIDTH]};
        q_fix    = neg_q ? -quo_n : quo_n;
        r_fix    = neg_r ? -rem_n : rem_n;
        calc_res = rem_sel ? r_fix : q_fix;
        last     = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = special ? DONE : CALC;
            CALC: if (last) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end

    assign busy = (state == CALC) | ((state == IDLE) & start & ~flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: if (start) begin
                        rem_sel <= op[1];
                        if (special) begin
                            result <= special_res;
                            done   <= 1'b1;
                        end else begin
                            quo   <= abs1;
                            dvs   <= abs2;
                            rem   <= '0;
                            cnt   <= '0;
                            neg_q <= sign1 ^ sign2;
                            neg_r <= sign1;
                        end
                    end
                    CALC: begin
                        rem <= rem_n;
                        quo <= quo_n;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            result <= calc_res;
                            done   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
